// File: rtl/window_gen_3x3.sv
// Streaming 3x3 sliding-window generator: two line buffers plus a 3x3 register window,
// one raster pixel in and up to one window out per cycle, valid/ready on both sides.
module window_gen_3x3 #(
  parameter int unsigned H  = 28,
  parameter int unsigned W  = 28,
  parameter int unsigned DW = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DW-1:0]         in_pixel,
  output logic                  in_ready,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic [9*DW-1:0]       win_data,
  output logic [$clog2(H)-1:0]  win_row,
  output logic [$clog2(W)-1:0]  win_col,
  output logic                  win_last
);

  localparam int unsigned RW   = $clog2(H);
  localparam int unsigned CW   = $clog2(W);
  localparam int unsigned WINW = 9 * DW;

  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [WINW-1:0] win_q, win_d;
  logic            win_valid_q, win_valid_d;
  logic [RW-1:0]   win_row_q, win_row_d;
  logic [CW-1:0]   win_col_q, win_col_d;
  logic            win_last_q, win_last_d;

  logic [DW-1:0]   lb0_q [W];
  logic [DW-1:0]   lb1_q [W];

  logic            accept;
  logic            complete;

  assign in_ready  = !win_valid_q || win_ready;
  assign accept    = in_valid && in_ready;
  assign complete  = (row_q >= RW'(2)) && (col_q >= CW'(2));

  assign win_valid = win_valid_q;
  assign win_data  = win_q;
  assign win_row   = win_row_q;
  assign win_col   = win_col_q;
  assign win_last  = win_last_q;

  // Next state: raster counters, window shift and output handshake.
  always_comb begin
    row_d       = row_q;
    col_d       = col_q;
    win_d       = win_q;
    win_valid_d = win_valid_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    win_last_d  = win_last_q;

    if (accept) begin
      if (col_q == CW'(W - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(H - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end

      for (int i = 0; i < 3; i++) begin
        win_d[(3*i)*DW   +: DW] = win_q[(3*i+1)*DW +: DW];
        win_d[(3*i+1)*DW +: DW] = win_q[(3*i+2)*DW +: DW];
      end
      win_d[2*DW +: DW] = lb1_q[col_q];
      win_d[5*DW +: DW] = lb0_q[col_q];
      win_d[8*DW +: DW] = in_pixel;

      win_valid_d = complete;
      win_last_d  = complete && (row_q == RW'(H - 1)) && (col_q == CW'(W - 1));
      if (complete) begin
        win_row_d = row_q - RW'(2);
        win_col_d = col_q - CW'(2);
      end
    end else if (win_ready) begin
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q       <= '0;
      col_q       <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      win_last_q  <= 1'b0;
    end else begin
      row_q       <= row_d;
      col_q       <= col_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      win_last_q  <= win_last_d;
    end
  end

  // Line buffers are plain storage; stale contents are never emitted.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= in_pixel;
    end
  end

endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed bench for window_gen_3x3: formula-based scoreboard on every retired window
// plus a hand-computed checkpoint table and stall / reset / latency sequences.
module tb_window_gen_3x3;

  localparam int H    = 28;
  localparam int W    = 28;
  localparam int DW   = 8;
  localparam int NWIN = (H - 2) * (W - 2);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic [DW-1:0]        in_pixel;
  logic                 in_ready;
  logic                 win_valid;
  logic                 win_ready;
  logic [9*DW-1:0]      win_data;
  logic [$clog2(H)-1:0] win_row;
  logic [$clog2(W)-1:0] win_col;
  logic                 win_last;

  window_gen_3x3 #(.H(H), .W(W), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_pixel  (in_pixel),
    .in_ready  (in_ready),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_data  (win_data),
    .win_row   (win_row),
    .win_col   (win_col),
    .win_last  (win_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  function automatic logic [7:0] pix(input int r, input int c, input int off);
    return 8'(r * W + c + off);
  endfunction

  function automatic logic [71:0] exp_win(input int r, input int c, input int off);
    logic [71:0] v;
    v = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        v[(3*i+j)*8 +: 8] = pix(r + i, c + j, off);
    return v;
  endfunction

  // Scoreboard state
  int          win_idx, acc_cnt, tot_win, last_cnt, er, ec;
  bit          lat_arm;
  int          off_q[$];
  logic [71:0] cap      [NWIN];
  logic        cap_last [NWIN];

  initial begin
    win_idx = 0; acc_cnt = 0; tot_win = 0; last_cnt = 0; lat_arm = 0;
  end

  always @(negedge clk) begin
    if (!rst) begin
      win_idx = 0;
      acc_cnt = 0;
      lat_arm = 0;
      off_q.delete();
    end else begin
      if (lat_arm) begin
        check("latency_valid", 72'(win_valid), 72'(1));
        check("latency_pos", 72'({win_row, win_col}), 72'(0));
        lat_arm = 0;
      end
      if (in_valid && in_ready) begin
        if (acc_cnt == 2 * W + 2) begin
          if (win_ready) check("pre_latency_valid", 72'(win_valid), 72'(0));
          lat_arm = 1;
        end
        acc_cnt = (acc_cnt + 1) % (H * W);
      end
      if (win_valid && win_ready) begin
        if (off_q.size() == 0) begin
          check("unexpected_window", 72'(1), 72'(0));
        end else begin
          er = win_idx / (W - 2);
          ec = win_idx % (W - 2);
          check($sformatf("win_data_%0d_%0d", er, ec), win_data, exp_win(er, ec, off_q[0]));
          check($sformatf("win_pos_%0d_%0d", er, ec), 72'({win_row, win_col}),
                72'({5'(er), 5'(ec)}));
          check($sformatf("win_last_%0d_%0d", er, ec), 72'(win_last), 72'(win_idx == NWIN - 1));
          cap[win_idx]      = win_data;
          cap_last[win_idx] = win_last;
          tot_win++;
          if (win_last) last_cnt++;
          win_idx++;
          if (win_idx == NWIN) begin
            win_idx = 0;
            off_q.delete(0);
          end
        end
      end
    end
  end

  task automatic drive_pixel(input logic [7:0] p, input bit bubble);
    int t;
    if (bubble && ($urandom_range(0, 1) == 1)) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_pixel = p;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 200);
    if (!in_ready) check("accept_timeout", 72'(0), 72'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic mid_reset();
    rst      = 1'b0;
    in_valid = 1'b1;
    #1;
    check("midrst_win_valid", 72'(win_valid), 72'(0));
    check("midrst_win_data", win_data, 72'(0));
    check("midrst_in_ready", 72'(in_ready), 72'(1));
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b1;
  endtask

  task automatic send_frame(input int off, input bit bubble, input int ab_r, input int ab_c);
    off_q.push_back(off);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (r == ab_r && c == ab_c) begin
          mid_reset();
          return;
        end
        drive_pixel(pix(r, c, off), bubble);
      end
  endtask

  typedef struct {
    int r;
    int c;
    int off;
    int px[9];
    bit last;
  } chk_t;

  chk_t tbl[7];

  task automatic apply_table(input int off, input string tag);
    logic [71:0] v;
    int idx;
    for (int n = 0; n < 7; n++) begin
      if (tbl[n].off == off) begin
        v = '0;
        for (int k = 0; k < 9; k++) v[k*8 +: 8] = 8'(tbl[n].px[k]);
        idx = tbl[n].r * (W - 2) + tbl[n].c;
        check($sformatf("tbl_%s_%0d_%0d", tag, tbl[n].r, tbl[n].c), cap[idx], v);
        check($sformatf("tbl_last_%s_%0d_%0d", tag, tbl[n].r, tbl[n].c),
              72'(cap_last[idx]), 72'(tbl[n].last));
      end
    end
  endtask

  task automatic check_count(input string tag, input int base_w, input int base_l, input int frames);
    repeat (5) @(posedge clk);
    #1;
    check({"count_", tag}, 72'(tot_win - base_w), 72'(frames * NWIN));
    check({"lastcnt_", tag}, 72'(last_cnt - base_l), 72'(frames));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bw, bl, t;
    logic [71:0] snap_d;
    logic [9:0]  snap_p;

    tbl[0] = '{0, 0, 0,   '{0, 1, 2, 28, 29, 30, 56, 57, 58}, 1'b0};
    tbl[1] = '{0, 1, 0,   '{1, 2, 3, 29, 30, 31, 57, 58, 59}, 1'b0};
    tbl[2] = '{1, 0, 0,   '{28, 29, 30, 56, 57, 58, 84, 85, 86}, 1'b0};
    tbl[3] = '{8, 10, 0,  '{234, 235, 236, 6, 7, 8, 34, 35, 36}, 1'b0};
    tbl[4] = '{25, 25, 0, '{213, 214, 215, 241, 242, 243, 13, 14, 15}, 1'b1};
    tbl[5] = '{0, 0, 100, '{100, 101, 102, 128, 129, 130, 156, 157, 158}, 1'b0};
    tbl[6] = '{25, 25, 100, '{57, 58, 59, 85, 86, 87, 113, 114, 115}, 1'b1};

    // Reset held with a pixel offered
    rst = 1'b0; in_valid = 1'b1; in_pixel = 8'hAA; win_ready = 1'b1;
    #12;
    check("rst_in_ready", 72'(in_ready), 72'(1));
    check("rst_win_valid", 72'(win_valid), 72'(0));
    check("rst_win_data", win_data, 72'(0));
    check("rst_win_pos", 72'({win_row, win_col}), 72'(0));
    check("rst_win_last", 72'(win_last), 72'(0));
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b1;

    // Gap-free frame, consumer always ready
    bw = tot_win; bl = last_cnt;
    send_frame(0, 0, -1, -1);
    check_count("plain", bw, bl, 1);
    apply_table(0, "plain");

    // Backpressure in the middle of a frame
    bw = tot_win; bl = last_cnt;
    fork
      send_frame(0, 0, -1, -1);
      begin
        repeat (300) @(posedge clk);
        #1;
        win_ready = 1'b0;
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!win_valid && t < 50);
        check("stall_window_seen", 72'(win_valid), 72'(1));
        snap_d = win_data;
        snap_p = {win_row, win_col};
        repeat (5) begin
          @(negedge clk);
          check("stall_data", win_data, snap_d);
          check("stall_pos", 72'({win_row, win_col}), 72'(snap_p));
          check("stall_valid", 72'(win_valid), 72'(1));
          check("stall_in_ready", 72'(in_ready), 72'(0));
        end
        @(posedge clk);
        #1;
        win_ready = 1'b1;
      end
    join
    check_count("stall", bw, bl, 1);

    // Random input bubbles
    bw = tot_win; bl = last_cnt;
    send_frame(0, 1, -1, -1);
    check_count("bubble", bw, bl, 1);

    // Two frames back to back, second offset by 100
    bw = tot_win; bl = last_cnt;
    send_frame(0, 0, -1, -1);
    send_frame(100, 0, -1, -1);
    check_count("b2b", bw, bl, 2);
    apply_table(100, "b2b");

    // Reset at pixel (10,5), then a fresh full frame
    send_frame(0, 0, 10, 5);
    bw = tot_win; bl = last_cnt;
    send_frame(0, 0, -1, -1);
    check_count("after_rst", bw, bl, 1);
    apply_table(0, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
